stitch_pipe_vr: RTL

- Parametrised successor to the fixed two-stage stitched pipeline wrapper with a valid chain.
- Generalises the stage count and data width, and adds full valid/ready backpressure with bubble collapsing.
- Stage k adds 2^k to its operand, so the pipe computes out = x + (2^STAGES - 1) mod 2^WIDTH.
- Sits between a DSLX-generated datapath and a ready/valid stream consumer; intended as the template for generated stitched pipelines.

---
 rtl/stitch_pipe_vr_if.sv | 21 ++
 rtl/stitch_pipe_vr.sv | 97 +++++++++
 2 files changed

// File: rtl/stitch_pipe_vr_if.sv
// Ready/valid stream bundle for stitch_pipe_vr: upstream operand stream in, result stream out.
interface stitch_pipe_vr_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             input_valid;
  logic             input_ready;
  logic [WIDTH-1:0] x;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;

  modport master (
    output input_valid, x, out_ready,
    input  input_ready, out_valid, out
  );

  modport slave (
    input  input_valid, x, out_ready,
    output input_ready, out_valid, out
  );
endinterface

// File: rtl/stitch_pipe_vr.sv
// Stitched pipeline with ready/valid backpressure; stage k adds 2^k, so out = x + 2^STAGES - 1.
// Optional macro STITCH_PIPE_FLUSH_EN adds a synchronous flush input that drops all tokens.
module stitch_pipe_vr #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
`ifdef STITCH_PIPE_FLUSH_EN
  input  logic             flush,
`endif
  stitch_pipe_vr_if.slave  bus
);

  localparam int NREG = int'(STAGES) + 1;

  if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
    $error("stitch_pipe_vr: WIDTH must be in 2..64");
  end
  if (STAGES < 1 || STAGES > WIDTH - 1) begin : g_bad_stages
    $error("stitch_pipe_vr: STAGES must be in 1..WIDTH-1");
  end

  logic [WIDTH-1:0] d_q [NREG];
  logic [WIDTH-1:0] d_d [NREG];
  logic [NREG-1:0]  v_q, v_d;
  logic [NREG-1:0]  r;
  logic             ready_in;
  logic [WIDTH-1:0] stage_out [STAGES];

  // Only bits [WIDTH-1:k] take part in the increment; low bits pass through untouched.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_lsb
      assign stage_out[k] = d_q[k] + WIDTH'(1);
    end else begin : g_upper
      assign stage_out[k] = {d_q[k][WIDTH-1:k] + (WIDTH-k)'(1), d_q[k][k-1:0]};
    end
  end

  always_comb begin
    logic acc;
    // Slot i can load if it or any slot downstream of it has a hole, or the sink drains.
    for (int i = 0; i < NREG; i++) begin
      acc = bus.out_ready;
      for (int j = i; j < NREG; j++) begin
        acc = acc | ~v_q[j];
      end
      r[i] = acc;
    end

    ready_in = r[0];
`ifdef STITCH_PIPE_FLUSH_EN
    ready_in = r[0] | flush;
`endif

    v_d = v_q;
    d_d = d_q;
    if (r[0]) begin
      v_d[0] = bus.input_valid;
      d_d[0] = bus.x;
    end
    for (int i = 1; i < NREG; i++) begin
      if (r[i]) begin
        v_d[i] = v_q[i-1];
        d_d[i] = stage_out[i-1];
      end
    end
`ifdef STITCH_PIPE_FLUSH_EN
    if (flush) v_d = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q <= '0;
      for (int i = 0; i < NREG; i++) d_q[i] <= '0;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  assign bus.out         = d_q[NREG-1];
  assign bus.out_valid   = v_q[NREG-1];
  assign bus.input_ready = ready_in;

`ifndef SYNTHESIS
`ifdef STITCH_PIPE_FLUSH_EN
  a_out_stable: assert property (@(posedge clk) disable iff (!rst)
    (bus.out_valid && !bus.out_ready && !flush) |=> (bus.out_valid && $stable(bus.out)));
`else
  a_out_stable: assert property (@(posedge clk) disable iff (!rst)
    (bus.out_valid && !bus.out_ready) |=> (bus.out_valid && $stable(bus.out)));
`endif
`endif

endmodule
